// File: rtl/sobel_pkg.sv
// Shared widths, width helpers and direction-bin codes for the Sobel gradient engine.
package sobel_pkg;

    localparam int unsigned DEF_PIX_W = 8;

    localparam logic [1:0] DIR_H    = 2'd0;
    localparam logic [1:0] DIR_D45  = 2'd1;
    localparam logic [1:0] DIR_V    = 2'd2;
    localparam logic [1:0] DIR_D135 = 2'd3;

    // One column tap sum is at most 4*max_pixel, so a signed difference needs 3 extra bits.
    function automatic int unsigned grad_w(input int unsigned pix_w);
        return pix_w + 3;
    endfunction

    function automatic int unsigned mag_w(input int unsigned pix_w);
        return pix_w + 3;
    endfunction

endpackage

// File: rtl/sobel_kernel3.sv
// Combinational 3x3 Sobel kernel: left/centre/right columns in, signed gx/gy out.
module sobel_kernel3
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W  = DEF_PIX_W,
    parameter int unsigned GRAD_W = grad_w(PIX_W)
) (
    input  logic [3*PIX_W-1:0]       col_l,
    input  logic [3*PIX_W-1:0]       col_r,
    input  logic [PIX_W-1:0]         c_top,
    input  logic [PIX_W-1:0]         c_bot,
    output logic signed [GRAD_W-1:0] gx,
    output logic signed [GRAD_W-1:0] gy
);

    logic [PIX_W-1:0] lt, lm, lb;
    logic [PIX_W-1:0] rt, rm, rb;

    assign {lb, lm, lt} = col_l;
    assign {rb, rm, rt} = col_r;

    logic signed [GRAD_W-1:0] l_sum, r_sum, t_sum, b_sum;

    // Partial sums are non-negative and fit below the sign bit; the differences wrap correctly.
    always_comb begin
        l_sum = GRAD_W'(lt) + (GRAD_W'(lm) << 1) + GRAD_W'(lb);
        r_sum = GRAD_W'(rt) + (GRAD_W'(rm) << 1) + GRAD_W'(rb);
        t_sum = GRAD_W'(lt) + (GRAD_W'(c_top) << 1) + GRAD_W'(rt);
        b_sum = GRAD_W'(lb) + (GRAD_W'(c_bot) << 1) + GRAD_W'(rb);
        gx    = l_sum - r_sum;
        gy    = t_sum - b_sum;
    end

endmodule

// File: rtl/sobel_grad_engine.sv
// Streaming 3x3 Sobel gradient engine with a 2-stage valid/ready pipeline.
// Optional per-direction magnitude histogram when SOBEL_GRAD_HIST_EN is defined.
module sobel_grad_engine
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W  = DEF_PIX_W,
    parameter int unsigned GRAD_W = grad_w(PIX_W),
    parameter int unsigned MAG_W  = mag_w(PIX_W)
`ifdef SOBEL_GRAD_HIST_EN
    ,
    parameter int unsigned HIST_W = 20
`endif
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3*PIX_W-1:0]       in_col,
    input  logic                     in_row_start,
    input  logic                     in_row_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [GRAD_W-1:0] out_gx,
    output logic signed [GRAD_W-1:0] out_gy,
    output logic [MAG_W-1:0]         out_mag,
    output logic [1:0]               out_dir,
    output logic                     out_last
`ifdef SOBEL_GRAD_HIST_EN
    ,
    input  logic                     hist_clr,
    output logic [4*HIST_W-1:0]      hist_sum
`endif
);

    logic en, accept, win_done;

    assign en       = out_ready || !out_valid;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Window: the oldest column is only consumed as c1 at the completing accept,
    // so two stored columns plus the incoming one form the full 3x3 window.
    logic [1:0]         cnt_q, cnt_d;
    logic [3*PIX_W-1:0] c1_q, c2_q;

    assign win_done = accept && !in_row_start && (cnt_q >= 2'd2);

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            if (in_row_start) begin
                cnt_d = 2'd1;
            end else if (cnt_q != 2'd3) begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 2'd0;
            c1_q  <= '0;
            c2_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                c1_q <= c2_q;
                c2_q <= in_col;
            end
        end
    end

    logic signed [GRAD_W-1:0] k_gx, k_gy;

    sobel_kernel3 #(
        .PIX_W  (PIX_W),
        .GRAD_W (GRAD_W)
    ) u_kernel (
        .col_l (c1_q),
        .col_r (in_col),
        .c_top (c2_q[PIX_W-1:0]),
        .c_bot (c2_q[3*PIX_W-1:2*PIX_W]),
        .gx    (k_gx),
        .gy    (k_gy)
    );

    // Stage 1: capture raw gradients.
    logic                     s1_valid_q, s1_last_q;
    logic signed [GRAD_W-1:0] s1_gx_q, s1_gy_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_gx_q    <= '0;
            s1_gy_q    <= '0;
        end else if (en) begin
            s1_valid_q <= win_done;
            if (win_done) begin
                s1_gx_q   <= k_gx;
                s1_gy_q   <= k_gy;
                s1_last_q <= in_row_last;
            end
        end
    end

    // Stage 2 combinational: L1 magnitude and direction bin.
    logic [GRAD_W-1:0] ax_g, ay_g;
    logic [MAG_W-1:0]  ax, ay, mag_d;
    logic [MAG_W:0]    ax_x2, ay_x2;
    logic [1:0]        dir_d;

    always_comb begin
        ax_g  = s1_gx_q[GRAD_W-1] ? $unsigned(-s1_gx_q) : $unsigned(s1_gx_q);
        ay_g  = s1_gy_q[GRAD_W-1] ? $unsigned(-s1_gy_q) : $unsigned(s1_gy_q);
        ax    = MAG_W'(ax_g);
        ay    = MAG_W'(ay_g);
        mag_d = ax + ay;
        ax_x2 = {ax, 1'b0};
        ay_x2 = {ay, 1'b0};
        if (ay_x2 <= {1'b0, ax}) begin
            dir_d = DIR_H;
        end else if (ax_x2 <= {1'b0, ay}) begin
            dir_d = DIR_V;
        end else if (s1_gx_q[GRAD_W-1] == s1_gy_q[GRAD_W-1]) begin
            dir_d = DIR_D45;
        end else begin
            dir_d = DIR_D135;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_gx    <= '0;
            out_gy    <= '0;
            out_mag   <= '0;
            out_dir   <= 2'd0;
            out_last  <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out_gx   <= s1_gx_q;
                out_gy   <= s1_gy_q;
                out_mag  <= mag_d;
                out_dir  <= dir_d;
                out_last <= s1_last_q;
            end
        end
    end

`ifdef SOBEL_GRAD_HIST_EN
    localparam int unsigned SumW = ((HIST_W > MAG_W) ? HIST_W : MAG_W) + 1;

    logic [HIST_W-1:0] hist_q [4];
    logic [HIST_W-1:0] hist_d [4];
    logic [SumW-1:0]   hist_add;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            hist_d[b] = hist_q[b];
        end
        hist_add = SumW'(hist_q[out_dir]) + SumW'(out_mag);
        // Clear wins; a coincident sample is intentionally dropped.
        if (hist_clr) begin
            for (int b = 0; b < 4; b++) begin
                hist_d[b] = '0;
            end
        end else if (out_valid && out_ready) begin
            hist_d[out_dir] = (hist_add > SumW'({HIST_W{1'b1}})) ? {HIST_W{1'b1}}
                                                                 : hist_add[HIST_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 4; b++) begin
                hist_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                hist_q[b] <= hist_d[b];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_hist_out
        assign hist_sum[g*HIST_W +: HIST_W] = hist_q[g];
    end
`endif

endmodule

// File: tb/tb_sobel_grad_engine.sv
// Directed self-checking bench for sobel_grad_engine (histogram checks when SOBEL_GRAD_HIST_EN).
`timescale 1ns/1ps
module tb_sobel_grad_engine;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned GRAD_W = 11;
    localparam int unsigned MAG_W  = 11;
    localparam int          NCOL   = 16;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [3*PIX_W-1:0]       in_col = '0;
    logic                     in_row_start = 1'b0;
    logic                     in_row_last = 1'b0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [GRAD_W-1:0] out_gx, out_gy;
    logic [MAG_W-1:0]         out_mag;
    logic [1:0]               out_dir;
    logic                     out_last;

    always #5 clk = ~clk;

`ifdef SOBEL_GRAD_HIST_EN
    logic                     hist_clr = 1'b0;
    logic [79:0]              hist_sum;
    logic [39:0]              hist_sum10;
    logic                     n_in_ready, n_out_valid, n_out_last;
    logic signed [GRAD_W-1:0] n_gx, n_gy;
    logic [MAG_W-1:0]         n_mag;
    logic [1:0]               n_dir;

    sobel_grad_engine #(.PIX_W(PIX_W), .HIST_W(20)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
        .in_row_start(in_row_start), .in_row_last(in_row_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_gx(out_gx), .out_gy(out_gy), .out_mag(out_mag),
        .out_dir(out_dir), .out_last(out_last), .hist_clr(hist_clr), .hist_sum(hist_sum)
    );

    sobel_grad_engine #(.PIX_W(PIX_W), .HIST_W(10)) u_dut10 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(n_in_ready), .in_col(in_col),
        .in_row_start(in_row_start), .in_row_last(in_row_last), .out_valid(n_out_valid),
        .out_ready(out_ready), .out_gx(n_gx), .out_gy(n_gy), .out_mag(n_mag),
        .out_dir(n_dir), .out_last(n_out_last), .hist_clr(hist_clr), .hist_sum(hist_sum10)
    );
`else
    sobel_grad_engine #(.PIX_W(PIX_W)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
        .in_row_start(in_row_start), .in_row_last(in_row_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_gx(out_gx), .out_gy(out_gy), .out_mag(out_mag),
        .out_dir(out_dir), .out_last(out_last)
    );
`endif

    typedef struct {
        int gx;
        int gy;
        int mag;
        int dir;
        int last;
    } res_t;

    res_t got[$];
    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int h1t = 0, h1m = 0, h1b = 0, h2t = 0, h2m = 0, h2b = 0, mcnt = 0;

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            got.push_back('{int'(out_gx), int'(out_gy), int'(out_mag), int'(out_dir),
                            int'(out_last)});
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic col(input int t, input int m, input int b, input logic rs, input logic rl);
        in_valid     = 1'b1;
        in_col       = {8'(b), 8'(m), 8'(t)};
        in_row_start = rs;
        in_row_last  = rl;
        step();
        in_valid     = 1'b0;
        in_row_start = 1'b0;
        in_row_last  = 1'b0;
    endtask

    task automatic expect_one(input string tag, input int gx, input int gy, input int mag,
                              input int dir, input int last);
        res_t r;
        check({tag, "_count"}, got.size(), 1);
        if (got.size() > 0) begin
            r = got.pop_front();
            check({tag, "_gx"}, r.gx, gx);
            check({tag, "_gy"}, r.gy, gy);
            check({tag, "_mag"}, r.mag, mag);
            check({tag, "_dir"}, r.dir, dir);
            check({tag, "_last"}, r.last, last);
        end
        got.delete();
    endtask

    function automatic res_t model(int lt, int lm, int lb, int ct, int cb,
                                   int rt, int rm, int rb, int last);
        res_t r;
        int   ax, ay;
        r.gx  = (lt + 2*lm + lb) - (rt + 2*rm + rb);
        r.gy  = (lt + 2*ct + rt) - (lb + 2*cb + rb);
        ax    = (r.gx < 0) ? -r.gx : r.gx;
        ay    = (r.gy < 0) ? -r.gy : r.gy;
        r.mag = ax + ay;
        if (2*ay <= ax)                   r.dir = 0;
        else if (2*ax <= ay)              r.dir = 2;
        else if ((r.gx < 0) == (r.gy < 0)) r.dir = 1;
        else                              r.dir = 3;
        r.last = last;
        return r;
    endfunction

    task automatic model_accept(input int t, input int m, input int b, input logic rs,
                                input logic rl);
        if (rs) begin
            mcnt = 1;
        end else begin
            if (mcnt >= 2) exp_q.push_back(model(h1t, h1m, h1b, h2t, h2b, t, m, b, int'(rl)));
            if (mcnt < 3) mcnt++;
        end
        h1t = h2t; h1m = h2m; h1b = h2b;
        h2t = t;   h2m = m;   h2b = b;
    endtask

`ifdef SOBEL_GRAD_HIST_EN
    task automatic check_bins(input string tag, input logic [79:0] s, input int w,
                              input int e0, input int e1, input int e2, input int e3);
        int e[4];
        logic [79:0] mask;
        e = '{e0, e1, e2, e3};
        mask = (80'd1 << w) - 80'd1;
        for (int b = 0; b < 4; b++) begin
            check($sformatf("%s_bin%0d", tag, b), int'((s >> (b*w)) & mask), e[b]);
        end
    endtask
`endif

    initial begin
        int   i, cyc;
        logic acc;
        int   pt[NCOL], pm[NCOL], pb[NCOL];

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_gx", int'(out_gx), 0);
        check("rst_gy", int'(out_gy), 0);
        check("rst_mag", out_mag, 0);
        check("rst_dir", out_dir, 0);
        check("rst_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        rstn = 1'b1;
        step();
`ifdef SOBEL_GRAD_HIST_EN
        check_bins("hist_rst", hist_sum, 20, 0, 0, 0, 0);
`endif

        // Flat field: three windows, last one tagged.
        col(100, 100, 100, 1'b1, 1'b0);
        col(100, 100, 100, 1'b0, 1'b0);
        col(100, 100, 100, 1'b0, 1'b0);
        col(100, 100, 100, 1'b0, 1'b0);
        col(100, 100, 100, 1'b0, 1'b1);
        repeat (4) step();
        check("flat_count", got.size(), 3);
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            check("flat_gx", got[k].gx, 0);
            check("flat_gy", got[k].gy, 0);
            check("flat_mag", got[k].mag, 0);
            check("flat_dir", got[k].dir, 0);
            check("flat_last", got[k].last, (k == 2) ? 1 : 0);
        end
        got.delete();

        // Vertical edge with exact latency.
        col(0, 0, 0, 1'b1, 1'b0);
        col(0, 0, 0, 1'b0, 1'b0);
        col(255, 255, 255, 1'b0, 1'b1);
        check("vert_not_yet", out_valid, 0);
        step();
        check("vert_valid", out_valid, 1);
        check("vert_gx", int'(out_gx), -1020);
        check("vert_gy", int'(out_gy), 0);
        check("vert_mag", out_mag, 1020);
        check("vert_dir", out_dir, 0);
        check("vert_last", out_last, 1);
        repeat (2) step();
        got.delete();

        col(255, 255, 0, 1'b1, 1'b0);
        col(255, 255, 0, 1'b0, 1'b0);
        col(255, 255, 0, 1'b0, 1'b1);
        repeat (3) step();
        expect_one("horiz", 0, 1020, 1020, 2, 1);

        col(255, 0, 0, 1'b1, 1'b0);
        col(0, 0, 0, 1'b0, 1'b0);
        col(0, 0, 0, 1'b0, 1'b1);
        repeat (3) step();
        expect_one("diag45", 255, 255, 510, 1, 1);

`ifdef SOBEL_GRAD_HIST_EN
        check_bins("hist4", hist_sum, 20, 1020, 510, 1020, 0);
        check_bins("hist4_w10", {40'd0, hist_sum10}, 10, 1020, 510, 1020, 0);
`endif

        // Direction boundaries: 2ay == ax -> H, 2ax == ay -> V; opposite signs -> D135.
        col(100, 50, 0, 1'b1, 1'b0);
        col(0, 0, 0, 1'b0, 1'b0);
        col(0, 0, 0, 1'b0, 1'b1);
        repeat (3) step();
        expect_one("bound_h", 200, 100, 300, 0, 1);

        col(100, 0, 0, 1'b1, 1'b0);
        col(50, 0, 0, 1'b0, 1'b0);
        col(0, 0, 0, 1'b0, 1'b1);
        repeat (3) step();
        expect_one("bound_v", 100, 200, 300, 2, 1);

        col(0, 0, 0, 1'b1, 1'b0);
        col(0, 0, 0, 1'b0, 1'b0);
        col(255, 0, 0, 1'b0, 1'b1);
        repeat (3) step();
        expect_one("diag135", -255, 255, 510, 3, 1);

`ifdef SOBEL_GRAD_HIST_EN
        check_bins("hist7", hist_sum, 20, 1320, 510, 1320, 510);
        check_bins("hist7_w10", {40'd0, hist_sum10}, 10, 1023, 510, 1023, 510);
        col(0, 0, 0, 1'b1, 1'b0);
        col(0, 0, 0, 1'b0, 1'b0);
        col(255, 255, 255, 1'b0, 1'b1);
        step();
        check("clr_hs_valid", out_valid, 1);
        hist_clr = 1'b1;
        step();
        hist_clr = 1'b0;
        check_bins("hist_clr", hist_sum, 20, 0, 0, 0, 0);
        repeat (2) step();
        got.delete();
`endif

        // Row restart discards prior columns.
        col(60, 60, 60, 1'b1, 1'b0);
        col(200, 10, 90, 1'b0, 1'b0);
        col(10, 20, 30, 1'b1, 1'b0);
        col(0, 0, 0, 1'b0, 1'b0);
        col(0, 0, 0, 1'b0, 1'b1);
        repeat (3) step();
        expect_one("restart", 80, -20, 100, 0, 1);

        // Async reset with a result in flight.
        col(50, 50, 50, 1'b1, 1'b0);
        col(200, 200, 200, 1'b0, 1'b0);
        col(7, 7, 7, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_gx", int'(out_gx), 0);
        check("arst_mag", out_mag, 0);
        check("arst_last", out_last, 0);
        step();
        rstn = 1'b1;
        col(9, 9, 9, 1'b0, 1'b0);
        col(90, 90, 90, 1'b0, 1'b0);
        repeat (4) step();
        check("arst_no_stale", got.size(), 0);
        got.delete();

        // Continuous stream with a 5-cycle downstream stall.
        for (int k = 0; k < NCOL; k++) begin
            pt[k] = (k * 37) % 256;
            pm[k] = (k * 91 + 13) % 256;
            pb[k] = (k * 53 + 200) % 256;
        end
        exp_q.delete();
        i   = 0;
        cyc = 0;
        while (i < NCOL && cyc < 200) begin
            out_ready    = !(cyc >= 6 && cyc < 11);
            in_valid     = 1'b1;
            in_col       = {8'(pb[i]), 8'(pm[i]), 8'(pt[i])};
            in_row_start = (i == 0);
            in_row_last  = (i == NCOL - 1);
            @(negedge clk);
            acc = in_ready;
            if (!out_ready) begin
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                if (got.size() < exp_q.size()) begin
                    check("bp_hold_mag", out_mag, exp_q[got.size()].mag);
                end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                model_accept(pt[i], pm[i], pb[i], (i == 0), (i == NCOL - 1));
                i++;
            end
            cyc++;
        end
        check("bp_no_timeout", i, NCOL);
        in_valid     = 1'b0;
        in_row_start = 1'b0;
        in_row_last  = 1'b0;
        out_ready    = 1'b1;
        repeat (4) step();
        check("bp_count", got.size(), exp_q.size());
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
            check($sformatf("bp%0d_gx", k), got[k].gx, exp_q[k].gx);
            check($sformatf("bp%0d_gy", k), got[k].gy, exp_q[k].gy);
            check($sformatf("bp%0d_mag", k), got[k].mag, exp_q[k].mag);
            check($sformatf("bp%0d_dir", k), got[k].dir, exp_q[k].dir);
            check($sformatf("bp%0d_last", k), got[k].last, exp_q[k].last);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
